fetch_buffer: RTL and testbench
===============================

// Module: fetch_buffer
// PURPOSE
//  - IF-stage block directly downstream of the program counter register.
//  - Each cycle it issues PCResult to the synchronous instruction memory and captures the returned word.
//  - It queues {instruction, PC+4} in a small FIFO for the IF/ID register / decode.
//  - It back-pressures the PC through PCHold so the PC's next-address mux re-selects PCResult.
//  - Flush discards everything fetched on a mispredicted / redirected path.
// PARAMETERS
//  DEPTH      4    FIFO entries; power of two, >=2
//  AW         32   instruction address width
//  DW         32   instruction width
// PORTS
//  Clk         in   1    clock, all state on posedge
//  Reset       in   1    synchronous, active-high
//  PCResult    in   AW   current PC from the PC register
//  PCHold      out  1    1 = upstream mux must feed PCResult back (PC holds)
//  IMemRd      out  1    fetch request this cycle
//  IMemAddr    out  AW   fetch address (= PCResult)
//  IMemRdData  in   DW   instruction; valid exactly 1 cycle after an IMemRd cycle
//  Flush       in   1    redirect: drop queued and in-flight fetches
//  OutValid    out  1    head entry valid
//  OutReady    in   1    decode accepts head entry
//  OutInstr    out  DW   head instruction
//  OutPCPlus4  out  AW   head PC+4
// BEHAVIOUR
//  - Reset: FIFO empty, in-flight flag 0, stored in-flight PC 0.
//    While Reset: OutValid=0, IMemRd=0, PCHold=0. OutInstr and OutPCPlus4 read 0 when the FIFO is empty.
//  - Credit: issue = !Reset && !Flush && (count + inflight < DEPTH).
//    Count includes a pop in the same cycle: count' = count - (OutValid&&OutReady).
//  - Issue cycle: IMemRd=1, IMemAddr=PCResult, PCHold=0, inflight<=1, inflight_pc<=PCResult.
//  - No-issue cycle, no Flush: IMemRd=0, PCHold=1 (PC frozen), inflight<=0.
//  - IMemAddr is combinational from PCResult. PCHold and IMemRd are combinational from the current state and the inputs.
//  - Response cycle (inflight==1, no Flush): push {IMemRdData, inflight_pc+4} at the tail.
//    PC+4 is modulo 2^AW: 0xFFFFFFFC -> 0x00000000.
//  - Pop: on OutValid && OutReady the head advances.
//    Push and pop in the same cycle are both honoured; count is unchanged.
//  - The credit rule guarantees no push when full. Overflow is a design error (assertion).
//  - Output: OutValid = (count != 0). The head is stable while OutValid && !OutReady.
//  - Fetch-to-OutValid latency is 2 cycles when the FIFO is empty: issue at t, push at t+1, visible at t+2.
//  - Flush (highest priority after Reset):
//    - FIFO cleared; the pop that cycle is ignored.
//    - inflight<=0; the response arriving next cycle is discarded.
//    - IMemRd=0, PCHold=0, so the PC loads the redirect target.
//    - Fetch resumes the following cycle from the new PCResult.
//  - Flush while inflight==1: the current-cycle response is also dropped, not pushed.
//  - Back-to-back Flush: each cycle behaves as above; no fetch issues.
//  - Reset mid-operation: identical to Flush plus pointer/count clear; takes precedence over Flush.
//  - Pointers wrap modulo DEPTH. count width is $clog2(DEPTH+1).
// STRUCTURE
//  - fetch_pkg:
//    - localparams DEPTH_DEF and PC_INC=4.
//    - fetch_entry_t = struct {DW instr; AW pc_plus4}.
//  - Sub-module fetch_fifo:
//    - Synchronous DEPTH x entry FIFO with push, pop, clear, count and head.
//    - Flop-based; read is not registered.
//  - Top level: credit/issue logic, in-flight register, PCHold, flush gating.
// TESTING
//  1. Reset, then PC stepping 0,4,8,... with OutReady=1 -> OutValid rises 2 cycles after the first IMemRd; entries {mem[0],4},{mem[4],8} appear one per cycle; PCHold stays 0.
//  2. OutReady=0 from start -> exactly DEPTH=4 fetches (addr 0..12) issue; PCHold=1 from cycle 4 on; OutValid held with OutPCPlus4=4 stable.
//  3. Full FIFO, then OutReady=1 for one cycle -> one pop and one new IMemRd (addr 16) that same cycle; count stays <=4.
//  4. Flush with 3 entries plus 1 in flight -> next cycle OutValid=0; the response word is not pushed; next IMemRd uses the redirect PC 0x40; first output is {mem[0x40],0x44}.
//  5. Push and pop simultaneously at count=2 -> count stays 2; order preserved.
//  6. Reset asserted with FIFO partly full and Flush high -> all outputs 0 next cycle; PCResult=0xFFFFFFFC fetch afterward yields OutPCPlus4=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and the FIFO entry layout for the IF-stage fetch buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//   DEPTH_DEF / AW_DEF / DW_DEF : default FIFO depth, address width, instruction width
//   PC_INC                      : byte stride between sequential instructions
//   fetch_entry_t               : {instr, pc_plus4} as queued for decode
package fetch_pkg;
  localparam int DEPTH_DEF = 4;
  localparam int AW_DEF    = 32;
  localparam int DW_DEF    = 32;
  localparam int PC_INC    = 4;

  typedef struct packed {
    logic [DW_DEF-1:0] instr;
    logic [AW_DEF-1:0] pc_plus4;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: flop-based DEPTH-entry FIFO of fetch_entry_t with synchronous clear.
// Latency: push visible at the head the next cycle; head read is combinational.
// Backpressure: none internally; the caller must never push when full (asserted).
//   Clk, Reset   : clock, synchronous active-high reset
//   i_clear      : synchronous clear (drops all entries; push/pop that cycle ignored)
//   i_push/_dat  : write an entry at the tail
//   i_pop        : advance the head
//   o_count      : current occupancy
//   o_head       : head entry, all zeros when empty
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          i_clear,
  input  logic          i_push,
  input  fetch_entry_t  i_push_dat,
  input  logic          i_pop,
  output logic [CW-1:0] o_count,
  output fetch_entry_t  o_head
);

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge Clk) begin
    if (Reset || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_dat;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset && !i_clear) begin
      assert (!(i_push && !i_pop && (r_count == CW'(DEPTH))));
      assert (!(i_pop && (r_count == '0)));
    end
  end

  assign o_count = r_count;
  assign o_head  = (r_count == '0) ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer: issues PCResult to the sync instruction memory and queues {instr, PC+4} for decode.
// Latency: issue at t, response pushed at t+1, OutValid at t+2 when the FIFO starts empty.
// Backpressure: a fetch issues only while queued + in-flight < DEPTH; otherwise PCHold freezes the PC.
//   Clk, Reset              : clock, synchronous active-high reset
//   PCResult / PCHold       : current PC in; hold request back to the PC mux
//   IMemRd/IMemAddr         : fetch request to instruction memory (address = PCResult)
//   IMemRdData              : instruction word, valid the cycle after IMemRd
//   Flush                   : redirect; drops queued and in-flight fetches
//   OutValid/OutReady       : head handshake with decode
//   OutInstr/OutPCPlus4     : head entry (zeros when empty)
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [AW-1:0] PCResult,
  output logic          PCHold,
  output logic          IMemRd,
  output logic [AW-1:0] IMemAddr,
  input  logic [DW-1:0] IMemRdData,
  input  logic          Flush,
  output logic          OutValid,
  input  logic          OutReady,
  output logic [DW-1:0] OutInstr,
  output logic [AW-1:0] OutPCPlus4
);

  localparam int CW = $clog2(DEPTH + 1);

  logic          r_inflight;
  logic [AW-1:0] r_inflight_pc;

  logic          w_kill;
  logic          w_pop;
  logic          w_issue;
  logic          w_push;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_count_after;
  logic [CW-1:0] w_used;
  fetch_entry_t  w_push_dat;
  fetch_entry_t  w_head;

  assign w_kill   = Reset || Flush;
  assign OutValid = !Reset && (w_count != '0);
  assign w_pop    = OutValid && OutReady;

  // A slot freed by this cycle's pop is already available as credit, so a
  // full FIFO being drained sustains one fetch per cycle.
  assign w_count_after = w_count - CW'(w_pop);
  assign w_used        = w_count_after + CW'(r_inflight);
  assign w_issue       = !w_kill && (w_used < CW'(DEPTH));

  assign IMemRd   = w_issue;
  assign IMemAddr = PCResult;
  // On a redirect PCHold drops so the PC mux loads the new target.
  assign PCHold   = !w_kill && !w_issue;

  // The response of an in-flight fetch is dropped if a redirect lands on it.
  assign w_push              = r_inflight && !w_kill;
  assign w_push_dat.instr    = IMemRdData;
  assign w_push_dat.pc_plus4 = r_inflight_pc + AW'(PC_INC);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= PCResult;
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .Clk        (Clk),
    .Reset      (Reset),
    .i_clear    (Flush),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop && !Flush),
    .o_count    (w_count),
    .o_head     (w_head)
  );

  assign OutInstr   = w_head.instr;
  assign OutPCPlus4 = w_head.pc_plus4;

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed stimulus with a PC-register model, a 1-cycle instruction
// memory model and a scoreboard of expected {instr, pc+4} entries.
module tb_fetch_buffer;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] PCResult;
  logic        PCHold;
  logic        IMemRd;
  logic [31:0] IMemAddr;
  logic [31:0] IMemRdData;
  logic        Flush;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] OutInstr;
  logic [31:0] OutPCPlus4;

  logic [31:0] redirect;
  logic [31:0] pc;

  int total = 0;
  int bad   = 0;

  fetch_entry_t exp_q[$];
  logic         pend;
  logic [31:0]  pend_addr;
  int           cyc;
  int           issue_cnt;
  int           first_issue;
  int           first_vld;

  logic        s_vld, s_rd, s_hold;
  logic [31:0] s_addr, s_instr, s_pcp4;

  always #5 Clk = ~Clk;

  fetch_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .PCResult   (PCResult),
    .PCHold     (PCHold),
    .IMemRd     (IMemRd),
    .IMemAddr   (IMemAddr),
    .IMemRdData (IMemRdData),
    .Flush      (Flush),
    .OutValid   (OutValid),
    .OutReady   (OutReady),
    .OutInstr   (OutInstr),
    .OutPCPlus4 (OutPCPlus4)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  // Program counter register with its next-address mux.
  always_ff @(posedge Clk) begin
    if (Reset)        pc <= '0;
    else if (Flush)   pc <= redirect;
    else if (!PCHold) pc <= pc + 32'd4;
  end
  assign PCResult = pc;

  // Synchronous instruction memory; returns junk when not read.
  always_ff @(posedge Clk) begin
    IMemRdData <= IMemRd ? mem_fn(IMemAddr) : 32'hDEADBEEF;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: sample at the falling edge, score, then return just after the rising edge.
  task automatic tick();
    int   sz;
    logic pop;
    logic exp_iss;
    fetch_entry_t e;
    @(negedge Clk);
    sz      = exp_q.size();
    s_vld   = OutValid;
    s_rd    = IMemRd;
    s_addr  = IMemAddr;
    s_hold  = PCHold;
    s_instr = OutInstr;
    s_pcp4  = OutPCPlus4;
    if (Reset) begin
      chk("rst_outvalid", OutValid, 0);
      chk("rst_imemrd", IMemRd, 0);
      chk("rst_pchold", PCHold, 0);
      exp_q.delete();
      pend = 1'b0;
    end else begin
      chk("outvalid", OutValid, (sz != 0));
      if (sz != 0) begin
        chk("head_instr", OutInstr, exp_q[0].instr);
        chk("head_pcp4", OutPCPlus4, exp_q[0].pc_plus4);
      end else begin
        chk("empty_instr", OutInstr, 0);
        chk("empty_pcp4", OutPCPlus4, 0);
      end
      pop     = (sz != 0) && OutReady && !Flush;
      exp_iss = !Flush && ((sz - int'(pop) + int'(pend)) < DEPTH);
      chk("imemrd", IMemRd, exp_iss);
      chk("pchold", PCHold, !Flush && !exp_iss);
      chk("imemaddr", IMemAddr, pc);
      if (Flush) begin
        exp_q.delete();
        pend = 1'b0;
      end else begin
        if (pop) void'(exp_q.pop_front());
        if (pend) begin
          e.instr    = mem_fn(pend_addr);
          e.pc_plus4 = pend_addr + 32'd4;
          exp_q.push_back(e);
        end
        pend      = exp_iss;
        pend_addr = pc;
        if (exp_iss) begin
          issue_cnt++;
          if (first_issue < 0) first_issue = cyc;
        end
      end
      if (OutValid && first_vld < 0) first_vld = cyc;
    end
    cyc++;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    Flush = 1'b0;
    tick();
    tick();
    Reset       = 1'b0;
    cyc         = 0;
    issue_cnt   = 0;
    first_issue = -1;
    first_vld   = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; Flush = 1'b0; OutReady = 1'b0; redirect = '0;
    pend = 1'b0; pend_addr = '0; cyc = 0; issue_cnt = 0;
    first_issue = -1; first_vld = -1;

    // 1: streaming with decode always ready
    OutReady = 1'b1;
    do_reset();
    repeat (8) tick();
    chk("latency", 64'(first_vld - first_issue), 2);
    chk("stream_no_hold", s_hold, 0);

    // 2: decode stalled from the start
    OutReady = 1'b0;
    do_reset();
    repeat (8) tick();
    chk("stall_issue_cnt", 64'(issue_cnt), 4);
    chk("stall_pchold", s_hold, 1);
    chk("stall_head_pcp4", s_pcp4, 32'h4);
    chk("stall_head_instr", s_instr, mem_fn(32'h0));

    // 3: single pop from full
    OutReady = 1'b1;
    tick();
    chk("pop_refetch_rd", s_rd, 1);
    chk("pop_refetch_addr", s_addr, 32'h10);
    OutReady = 1'b0;
    repeat (3) tick();
    chk("after_pop_head", s_pcp4, 32'h8);
    chk("after_pop_full_hold", s_hold, 1);

    // 4: flush with 3 queued plus 1 in flight
    do_reset();
    repeat (4) tick();
    Flush = 1'b1; redirect = 32'h40; OutReady = 1'b1;
    tick();
    Flush = 1'b0; OutReady = 1'b0;
    tick();
    chk("flush_outvalid", s_vld, 0);
    chk("flush_refetch_addr", s_addr, 32'h40);
    chk("flush_refetch_rd", s_rd, 1);
    tick();
    tick();
    chk("flush_first_pcp4", s_pcp4, 32'h44);
    chk("flush_first_instr", s_instr, mem_fn(32'h40));

    // 5: simultaneous push and pop at count 2
    do_reset();
    repeat (3) tick();
    OutReady = 1'b1;
    tick();
    chk("pp_head0", s_pcp4, 32'h4);
    tick();
    chk("pp_head1", s_pcp4, 32'h8);
    tick();
    chk("pp_head2", s_pcp4, 32'hC);
    chk("pp_valid", s_vld, 1);

    // 6: reset over a partly full FIFO with flush high, then wrap at top of memory
    OutReady = 1'b0;
    tick();
    Reset = 1'b1; Flush = 1'b1;
    tick();
    chk("rst6_outvalid", s_vld, 0);
    chk("rst6_imemrd", s_rd, 0);
    Reset = 1'b0; Flush = 1'b0;
    tick();
    chk("post_rst_valid", s_vld, 0);
    chk("post_rst_instr", s_instr, 0);
    chk("post_rst_pcp4", s_pcp4, 0);
    Flush = 1'b1; redirect = 32'hFFFFFFFC;
    tick();
    Flush = 1'b0;
    tick();
    chk("wrap_fetch_addr", s_addr, 32'hFFFFFFFC);
    tick();
    tick();
    chk("wrap_valid", s_vld, 1);
    chk("wrap_pcp4", s_pcp4, 32'h0);
    chk("wrap_instr", s_instr, mem_fn(32'hFFFFFFFC));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
